decoder_3_8: RTL and testbench
==============================

// Module: decoder_3_8
// PURPOSE
// - 3-to-8 binary decoder with registered, one-hot, active-high outputs.
// - The 3-bit code {A2,A1,A0} selects exactly one of Y0..Y7 on the next clock edge.
// - Standalone leaf block in the decoder lab; feeds select/enable lines of downstream logic.
// PARAMETERS
// - none (widths fixed: 3-bit code, 8 outputs)
// PORTS
// clk  input   1  system clock; all state updates on rising edge
// rst  input   1  synchronous reset, active-high
// A0   input   1  select code bit 0 (LSB)
// A1   input   1  select code bit 1
// A2   input   1  select code bit 2 (MSB)
// Y0   output  1  high when registered code == 3'd0
// Y1   output  1  high when registered code == 3'd1
// Y2   output  1  high when registered code == 3'd2
// Y3   output  1  high when registered code == 3'd3
// Y4   output  1  high when registered code == 3'd4
// Y5   output  1  high when registered code == 3'd5
// Y6   output  1  high when registered code == 3'd6
// Y7   output  1  high when registered code == 3'd7
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high (rst).
// - Code n = {A2,A1,A0}, unsigned 0..7; Yn = 1 and all other Y = 0.
// - Latency: exactly 1 cycle. Inputs sampled on the rising edge of clk; Y updates on that same edge.
// - Outputs come straight from flops; no combinational path from A* to Y*.
// - Reset: when rst = 1 at a rising edge, Y0..Y7 = 0 (all-zero, the only legal non-one-hot state).
//   rst has priority over the decode.
// - First non-reset edge after reset: decodes the inputs at that edge (no extra bubble).
// - Reset asserted mid-stream: outputs go to 0 on that edge. Decoding resumes on the first edge with rst = 0.
// - Invariant out of reset: popcount(Y) == 1 every cycle.
// - Held inputs: outputs are held. Wrap-around 7 -> 0 needs no special case.
// - X/Z on A*: no requirement beyond simulation propagation. A* must be driven out of reset.
// STRUCTURE
// - Single module. No package needed.
// - One 8-bit output register, with a combinational one-hot decode (1 << n) in front of it.
// - Y0..Y7 are driven from individual bits of that register.
// TESTING
// - Reset: hold rst = 1 for 2 cycles with A = 3'd5 -> Y[7:0] = 8'h00 throughout.
// - Count sweep: rst = 0, {A2,A1,A0} = 0,1,...,7 one per cycle.
//   Required one cycle later: Y[7:0] = 01,02,04,08,10,20,40,80 (hex).
// - Wrap: 7 -> 0 -> 1 -> Y = 8'h80 -> 8'h01 -> 8'h02, one-hot every cycle.
// - Reset mid-operation: A = 3'd3 with rst pulsed for 1 cycle -> Y = 8'h00 that cycle, then 8'h08 the next.
// - Hold/latency: change A = 2 -> 6 between edges -> Y stays 8'h04 until the next edge, then 8'h40.
// - Assertion every non-reset cycle: $onehot(Y); Y == (1 << previous-cycle {A2,A1,A0}).

Source files
------------

// File: rtl/decoder_3_8_pkg.sv
// Shared types and the one-hot decode helper for the 3-to-8 decoder lab block.
package decoder_3_8_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 1 << CODE_W;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [OUT_W-1:0]  onehot_t;

  // All outputs low is the reset pattern and the only legal non-one-hot value.
  localparam onehot_t ONEHOT_IDLE = '0;

  // Turns a binary select code into a one-hot vector with bit 'code' set.
  function automatic onehot_t decode_onehot(input code_t code);
    onehot_t result;
    result = onehot_t'(1) << code;
    return result;
  endfunction

endpackage

// File: rtl/decoder_3_8.sv
// 3-to-8 binary decoder with registered, one-hot, active-high outputs.
// The code {A2,A1,A0} sampled at a rising edge selects exactly one Y on that
// same edge. Every Y comes directly from a flop, so A* never reaches Y*
// combinationally.
module decoder_3_8
  import decoder_3_8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic Y6,
  output logic Y7
);

  code_t   sel_code;
  onehot_t next_y;
  onehot_t y_q;

  assign sel_code = {A2, A1, A0};

  // Combinational one-hot decode that feeds the output register.
  always_comb begin
    next_y = decode_onehot(sel_code);
  end

  // Output register; reset wins over the decode and clears every line.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= ONEHOT_IDLE;
    end else begin
      y_q <= next_y;
    end
  end

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];
  assign Y4 = y_q[4];
  assign Y5 = y_q[5];
  assign Y6 = y_q[6];
  assign Y7 = y_q[7];

endmodule

// File: tb/tb_decoder_3_8.sv
// Self-checking bench for decoder_3_8: directed sequences plus randomized
// traffic, compared against a behavioural model built from plain arithmetic.
module tb_decoder_3_8;

  logic clk;
  logic rst;
  logic A0, A1, A2;
  logic Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7;
  logic [7:0] y_bus;

  int tests_run;
  int tests_failed;

  decoder_3_8 dut (
    .clk (clk),
    .rst (rst),
    .A0  (A0),
    .A1  (A1),
    .A2  (A2),
    .Y0  (Y0),
    .Y1  (Y1),
    .Y2  (Y2),
    .Y3  (Y3),
    .Y4  (Y4),
    .Y5  (Y5),
    .Y6  (Y6),
    .Y7  (Y7)
  );

  assign y_bus = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: with reset the outputs are all zero, otherwise the output
  // value is two raised to the sampled code.
  function automatic logic [7:0] model_y(input logic r, input int code);
    int value;
    if (r) value = 0;
    else   value = 2 ** code;
    return value[7:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives rst and the code between edges, then checks the registered result
  // just after the next rising edge, including the one-hot property.
  task automatic applyStimulus(input string tag, input logic r, input int code);
    logic [2:0] c;
    c = code[2:0];
    @(negedge clk);
    rst = r;
    {A2, A1, A0} = c;
    @(posedge clk);
    #1;
    checkOutput(tag, y_bus, model_y(r, code));
    if (!r) begin
      checkOutput({tag, "_onehot"}, 8'($countones(y_bus)), 8'd1);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    {A2, A1, A0} = 3'd5;

    // Reset held for two cycles with a non-zero code on the inputs.
    applyStimulus("reset0", 1'b1, 5);
    applyStimulus("reset1", 1'b1, 5);

    // Count sweep 0..7, then wrap back through 0 and 1.
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("sweep%0d", i), 1'b0, i);
    end
    applyStimulus("wrap0", 1'b0, 0);
    applyStimulus("wrap1", 1'b0, 1);

    // Reset pulsed mid-stream with code 3, then decoding resumes at once.
    applyStimulus("midrst", 1'b1, 3);
    applyStimulus("resume", 1'b0, 3);

    // Held input keeps the output steady.
    applyStimulus("held_a", 1'b0, 3);
    applyStimulus("held_b", 1'b0, 3);

    // Input change between edges must not show until the next edge.
    applyStimulus("hold2", 1'b0, 2);
    @(negedge clk);
    {A2, A1, A0} = 3'd6;
    #1;
    checkOutput("latency_hold", y_bus, 8'h04);
    @(posedge clk);
    #1;
    checkOutput("latency_upd", y_bus, 8'h40);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      int code;
      logic r;
      code = int'($urandom_range(7, 0));
      r    = ($urandom_range(9, 0) == 0);
      applyStimulus("random", r, code);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
